// File: rtl/micro_pkg.sv
// Shared encodings for the microcode sequencer and the datapath blocks it drives.
package micro_pkg;

  localparam int unsigned CTRL_W  = 16;
  localparam int unsigned STAGE_W = 3;
  localparam int unsigned OP_W    = 4;

  // Stage encoding: T0..T5 are the instruction T-states, HALT and IDLE are parking states.
  typedef enum logic [STAGE_W-1:0] {
    ST_T0   = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_T3   = 3'd3,
    ST_T4   = 3'd4,
    ST_T5   = 3'd5,
    ST_HALT = 3'd6,
    ST_IDLE = 3'd7
  } stage_e;

  // Opcodes; anything else decodes as NOP.
  localparam logic [OP_W-1:0] OP_HLT = 4'd0;
  localparam logic [OP_W-1:0] OP_NOP = 4'd1;
  localparam logic [OP_W-1:0] OP_ADD = 4'd2;
  localparam logic [OP_W-1:0] OP_SUB = 4'd3;
  localparam logic [OP_W-1:0] OP_LDA = 4'd4;
  localparam logic [OP_W-1:0] OP_OUT = 4'd5;
  localparam logic [OP_W-1:0] OP_STA = 4'd6;
  localparam logic [OP_W-1:0] OP_JMP = 4'd7;
  localparam logic [OP_W-1:0] OP_JC  = 4'd8;
  localparam logic [OP_W-1:0] OP_JZ  = 4'd9;

  // Control word bit positions (suffix _N = active low).
  localparam int unsigned SIG_FLAGS_LOAD      = 15;
  localparam int unsigned SIG_PC_INC          = 14;
  localparam int unsigned SIG_PC_EN           = 13;
  localparam int unsigned SIG_PC_LOAD         = 12;
  localparam int unsigned SIG_MAR_ADDR_LOAD_N = 11;
  localparam int unsigned SIG_MAR_MEM_LOAD_N  = 10;
  localparam int unsigned SIG_RAM_EN_N        = 9;
  localparam int unsigned SIG_RAM_LOAD_N      = 8;
  localparam int unsigned SIG_IR_LOAD_N       = 7;
  localparam int unsigned SIG_IR_EN_N         = 6;
  localparam int unsigned SIG_REGA_LOAD_N     = 5;
  localparam int unsigned SIG_REGA_EN         = 4;
  localparam int unsigned SIG_ADDER_SUB       = 3;
  localparam int unsigned SIG_REGB_EN         = 2;
  localparam int unsigned SIG_REGB_LOAD_N     = 1;
  localparam int unsigned SIG_OUT_LOAD_N      = 0;

  // All active-low controls deasserted, all active-high controls low.
  localparam logic [CTRL_W-1:0] IDLE_WORD = 16'h0FE3;

  // Fold out-of-range opcodes (high bits set, or 10..15) onto NOP.
  function automatic logic [OP_W-1:0] op_norm(input logic [OP_W-1:0] op_lo, input logic hi_set);
    if (hi_set || (op_lo > OP_JZ)) return OP_NOP;
    return op_lo;
  endfunction

endpackage

// File: rtl/micro_sequencer_if.sv
// Sequencer <-> IR/flags/datapath bundle.
interface micro_sequencer_if #(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned CNT_W    = 16
);
  logic [OPCODE_W-1:0] opcode;
  logic                flag_c;
  logic                flag_z;
  logic                resume;
  logic [15:0]         ctrl;
  logic [2:0]          stage;
  logic                halted;
  logic                instr_done;
  logic [CNT_W-1:0]    instr_count;

  // Sequencer side.
  modport master (
    input  opcode, flag_c, flag_z, resume,
    output ctrl, stage, halted, instr_done, instr_count
  );

  // Datapath / observer side.
  modport slave (
    output opcode, flag_c, flag_z, resume,
    input  ctrl, stage, halted, instr_done, instr_count
  );
endinterface

// File: rtl/micro_decode.sv
// Combinational microcode ROM: control word and last-stage flag for a given stage.
module micro_decode
  import micro_pkg::*;
#(
  parameter int unsigned OPCODE_W = 4,
  parameter bit          VAR_LEN  = 1'b1
) (
  input  stage_e              stage,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                flag_c,
  input  logic                flag_z,
  output logic [CTRL_W-1:0]   ctrl_next,
  output logic                is_last
);

  logic [OP_W-1:0] op;
  logic            hi_set;
  logic            taken;
  stage_e          last_st;

  // Opcode normalisation and branch resolution.
  always_comb begin
    hi_set = ((opcode >> 4) != '0);
    op     = op_norm(opcode[OP_W-1:0], hi_set);
    taken  = (op == OP_JMP) || ((op == OP_JC) && flag_c) || ((op == OP_JZ) && flag_z);
  end

  // Final stage of the current instruction.
  always_comb begin
    case (op)
      OP_HLT, OP_NOP:                 last_st = ST_T2;
      OP_OUT, OP_JMP, OP_JC, OP_JZ:   last_st = ST_T3;
      OP_LDA:                         last_st = ST_T4;
      default:                        last_st = ST_T5;
    endcase
    // Legacy timing pads everything to T5; HLT still parks after fetch.
    if (!VAR_LEN && (op != OP_HLT)) last_st = ST_T5;
    is_last = (stage == last_st);
  end

  // Control word: start from idle, modify only the listed bits.
  always_comb begin
    ctrl_next = IDLE_WORD;
    case (stage)
      ST_T0: begin
        ctrl_next[SIG_PC_EN]           = 1'b1;
        ctrl_next[SIG_MAR_ADDR_LOAD_N] = 1'b0;
      end
      ST_T1: ctrl_next[SIG_PC_INC] = 1'b1;
      ST_T2: begin
        ctrl_next[SIG_RAM_EN_N]  = 1'b0;
        ctrl_next[SIG_IR_LOAD_N] = 1'b0;
      end
      ST_T3: begin
        if ((op == OP_ADD) || (op == OP_SUB) || (op == OP_LDA) || (op == OP_STA)) begin
          ctrl_next[SIG_IR_EN_N]         = 1'b0;
          ctrl_next[SIG_MAR_ADDR_LOAD_N] = 1'b0;
        end else if (op == OP_OUT) begin
          ctrl_next[SIG_REGA_EN]    = 1'b1;
          ctrl_next[SIG_OUT_LOAD_N] = 1'b0;
        end else if (taken) begin
          ctrl_next[SIG_IR_EN_N]  = 1'b0;
          ctrl_next[SIG_PC_LOAD]  = 1'b1;
        end
      end
      ST_T4: begin
        if ((op == OP_ADD) || (op == OP_SUB)) begin
          ctrl_next[SIG_RAM_EN_N]    = 1'b0;
          ctrl_next[SIG_REGB_LOAD_N] = 1'b0;
        end else if (op == OP_LDA) begin
          ctrl_next[SIG_RAM_EN_N]    = 1'b0;
          ctrl_next[SIG_REGA_LOAD_N] = 1'b0;
        end else if (op == OP_STA) begin
          ctrl_next[SIG_REGA_EN]        = 1'b1;
          ctrl_next[SIG_MAR_MEM_LOAD_N] = 1'b0;
        end
      end
      ST_T5: begin
        if ((op == OP_ADD) || (op == OP_SUB)) begin
          ctrl_next[SIG_REGB_EN]     = 1'b1;
          ctrl_next[SIG_REGA_LOAD_N] = 1'b0;
          ctrl_next[SIG_FLAGS_LOAD]  = 1'b1;
          ctrl_next[SIG_ADDER_SUB]   = (op == OP_SUB);
        end else if (op == OP_STA) begin
          ctrl_next[SIG_RAM_LOAD_N] = 1'b0;
        end
      end
      default: ctrl_next = IDLE_WORD;
    endcase
  end

endmodule

// File: rtl/micro_sequencer.sv
// Microcode sequencer: stage register, halt/resume, retirement counter; updates on the falling edge.
module micro_sequencer
  import micro_pkg::*;
#(
  parameter int unsigned OPCODE_W = 4,
  parameter bit          VAR_LEN  = 1'b1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  micro_sequencer_if.master   bus
);

  stage_e             stage_q;
  stage_e             stage_nxt;
  logic [CTRL_W-1:0]  ctrl_q;
  logic [CTRL_W-1:0]  ctrl_nxt;
  logic               halted_q;
  logic               done_q;
  logic               hlt_q;
  logic               last_nxt;
  logic               hlt_nxt;
  logic [CNT_W-1:0]   count_q;

  // Next-stage selection; done_q marks the current stage as the instruction's last.
  always_comb begin
    case (stage_q)
      ST_IDLE: stage_nxt = ST_T0;
      ST_HALT: stage_nxt = bus.resume ? ST_T0 : ST_HALT;
      default: begin
        if (done_q)                stage_nxt = hlt_q ? ST_HALT : ST_T0;
        else if (stage_q == ST_T5) stage_nxt = ST_T0;
        else                       stage_nxt = stage_e'(stage_q + 3'd1);
      end
    endcase
  end

  micro_decode #(
    .OPCODE_W (OPCODE_W),
    .VAR_LEN  (VAR_LEN)
  ) u_decode (
    .stage     (stage_nxt),
    .opcode    (bus.opcode),
    .flag_c    (bus.flag_c),
    .flag_z    (bus.flag_z),
    .ctrl_next (ctrl_nxt),
    .is_last   (last_nxt)
  );

  // HLT retires at T2 like any instruction but parks instead of refetching.
  assign hlt_nxt = last_nxt && (bus.opcode == OPCODE_W'(OP_HLT));

  // Stage and outputs registered together so ctrl always matches stage.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      stage_q  <= ST_IDLE;
      ctrl_q   <= IDLE_WORD;
      halted_q <= 1'b0;
      done_q   <= 1'b0;
      hlt_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      stage_q  <= stage_nxt;
      ctrl_q   <= ctrl_nxt;
      halted_q <= (stage_nxt == ST_HALT);
      done_q   <= last_nxt;
      hlt_q    <= hlt_nxt;
      if (done_q) count_q <= count_q + CNT_W'(1);
    end
  end

  assign bus.ctrl        = ctrl_q;
  assign bus.stage       = stage_q;
  assign bus.halted      = halted_q;
  assign bus.instr_done  = done_q;
  assign bus.instr_count = count_q;

endmodule
